// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined comparator: operation encoding and
// the final flag-to-result decode.
package cmp_pkg;

  typedef logic [2:0] cmp_op_t;

  localparam cmp_op_t CMP_EQ = 3'd0;
  localparam cmp_op_t CMP_NE = 3'd1;
  localparam cmp_op_t CMP_LT = 3'd2;
  localparam cmp_op_t CMP_LE = 3'd3;
  localparam cmp_op_t CMP_GT = 3'd4;
  localparam cmp_op_t CMP_GE = 3'd5;

  // c = 1 iff I0 >= I1, e = 1 iff I0 == I1; reserved encodings give 0
  function automatic logic cmp_decode(cmp_op_t op, logic c, logic e);
    case (op)
      CMP_EQ:  return e;
      CMP_NE:  return ~e;
      CMP_LT:  return ~c;
      CMP_LE:  return ~c | e;
      CMP_GT:  return c & ~e;
      CMP_GE:  return c;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/compare_pipe_if.sv
// Valid/ready transaction bus of the comparator. The slave modport is the
// comparator's view, the master modport the producer/consumer side.
interface compare_pipe_if
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  cmp_op_t          OP;
  logic             SIGNED;
  logic             O_VALID;
  logic             O_READY;
  logic             O;

  modport slave  (input  I_VALID, I0, I1, OP, SIGNED, O_READY,
                  output I_READY, O_VALID, O);
  modport master (output I_VALID, I0, I1, OP, SIGNED, O_READY,
                  input  I_READY, O_VALID, O);

endinterface

// File: rtl/cmp_slice.sv
// One pipeline stage of the comparator carry chain: resolves SLICE bits of
// A + B + cin and the running equality flag, then registers them. The last
// stage registers the decoded result instead of the flags.
module cmp_slice
  import cmp_pkg::*;
#(
  parameter int SLICE = 4,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  input  logic             eq_i,
  input  cmp_op_t          op_i,
  output logic             vld_o,
  output logic             c_o,
  output logic             eq_o,
  output cmp_op_t          op_o,
  output logic             res_o
);

  logic c_d;
  logic eq_d;
  logic vld_q;

  // Only the carry out of the slice sum matters; sum bits are discarded
  assign c_d  = 1'(({1'b0, a_i} + {1'b0, b_i} + (SLICE+1)'(cin_i)) >> SLICE);
  // B is the inverted right operand, so equal slices show up as a == ~b
  assign eq_d = eq_i & (a_i == ~b_i);

  // Stage valid bit; holds while the pipeline is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       vld_q <= 1'b0;
    else if (en_i) vld_q <= vld_i;
  end

  assign vld_o = vld_q;

  if (LAST) begin : g_last
    logic res_q;

    // Final stage: decode the complete flags straight into the output register
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       res_q <= 1'b0;
      else if (en_i) res_q <= cmp_decode(op_i, c_d, eq_d);
    end

    assign res_o = res_q;
    assign c_o   = 1'b0;
    assign eq_o  = 1'b0;
    assign op_o  = CMP_EQ;
  end else begin : g_mid
    logic    c_q;
    logic    eq_q;
    cmp_op_t op_q;

    // Intermediate stage: carry, equality and the op travel to the next slice
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        c_q  <= 1'b0;
        eq_q <= 1'b0;
        op_q <= CMP_EQ;
      end else if (en_i) begin
        c_q  <= c_d;
        eq_q <= eq_d;
        op_q <= op_i;
      end
    end

    assign res_o = 1'b0;
    assign c_o   = c_q;
    assign eq_o  = eq_q;
    assign op_o  = op_q;
  end

endmodule

// File: rtl/compare_pipe.sv
// Pipelined magnitude comparator: computes I0 - I1 as a carry chain split
// into WIDTH/SLICE registered segments. Carry out of the chain is I0 >= I1;
// a parallel equality chain gives I0 == I1. WIDTH must be a multiple of SLICE.
module compare_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic           CLK,
  input  logic           ASYNCRESET,
  compare_pipe_if.slave  bus
);

  localparam int STAGES = WIDTH / SLICE;

  logic             en;
  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;

  logic    [STAGES-1:0] vld_s;
  logic    [STAGES-1:0] c_s;
  logic    [STAGES-1:0] eq_s;
  logic    [STAGES-1:0] res_s;
  cmp_op_t [STAGES-1:0] op_s;

  // Flipping the MSBs maps two's complement onto biased unsigned order
  assign a_w = bus.I0 ^ {bus.SIGNED, {(WIDTH-1){1'b0}}};
  assign b_w = ~(bus.I1 ^ {bus.SIGNED, {(WIDTH-1){1'b0}}});

  // One global enable: every stage advances together, bubbles are kept
  assign en          = ~vld_s[STAGES-1] | bus.O_READY;
  assign bus.I_READY = en;
  assign bus.O_VALID = vld_s[STAGES-1];
  assign bus.O       = res_s[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int W_IN = WIDTH - k*SLICE;

    logic [W_IN-1:0] opa;
    logic [W_IN-1:0] opb;
    logic            vld_in;
    logic            cin;
    logic            eq_in;
    cmp_op_t         op_in;

    if (k == 0) begin : g_head
      assign opa    = a_w;
      assign opb    = b_w;
      assign vld_in = bus.I_VALID;
      assign cin    = 1'b1;
      assign eq_in  = 1'b1;
      assign op_in  = bus.OP;
    end else begin : g_link
      assign opa    = g_st[k-1].g_rem.rem_a_q;
      assign opb    = g_st[k-1].g_rem.rem_b_q;
      assign vld_in = vld_s[k-1];
      assign cin    = c_s[k-1];
      assign eq_in  = eq_s[k-1];
      assign op_in  = op_s[k-1];
    end

    if (k < STAGES-1) begin : g_rem
      logic [W_IN-SLICE-1:0] rem_a_q;
      logic [W_IN-SLICE-1:0] rem_b_q;

      // Operand slices not yet consumed ride along with the token
      always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else if (en) begin
          rem_a_q <= opa[W_IN-1:SLICE];
          rem_b_q <= opb[W_IN-1:SLICE];
        end
      end
    end

    cmp_slice #(
      .SLICE (SLICE),
      .LAST  (k == STAGES-1)
    ) u_slice (
      .clk   (CLK),
      .rst   (ASYNCRESET),
      .en_i  (en),
      .vld_i (vld_in),
      .a_i   (opa[SLICE-1:0]),
      .b_i   (opb[SLICE-1:0]),
      .cin_i (cin),
      .eq_i  (eq_in),
      .op_i  (op_in),
      .vld_o (vld_s[k]),
      .c_o   (c_s[k]),
      .eq_o  (eq_s[k]),
      .op_o  (op_s[k]),
      .res_o (res_s[k])
    );
  end

  // Tie-offs of the last stage flags and intermediate result ports
  logic unused_tie;
  assign unused_tie = ^{c_s, eq_s, op_s, res_s};

endmodule

// File: tb/tb_compare_pipe.sv
// Directed and randomized checks of compare_pipe in three shapes:
// 8/4 (two stages), 16/4 (four stages) and 8/8 (single stage).
module tb_compare_pipe;
  import cmp_pkg::*;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    cmp_op_t     op;
    logic        s;
    logic        e;
  } tok_t;

  logic CLK = 1'b0;
  logic ASYNCRESET = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  compare_pipe_if #(.WIDTH(8))  b8 ();
  compare_pipe_if #(.WIDTH(16)) b16 ();
  compare_pipe_if #(.WIDTH(8))  b88 ();

  compare_pipe #(.WIDTH(8),  .SLICE(4)) dut8  (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b8.slave));
  compare_pipe #(.WIDTH(16), .SLICE(4)) dut16 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b16.slave));
  compare_pipe #(.WIDTH(8),  .SLICE(8)) dut88 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b88.slave));

  // Integer reference: sign-extend when requested, compare, decode
  function automatic logic ref_cmp(int w, logic [15:0] x, logic [15:0] y, cmp_op_t op, logic s);
    longint a, b;
    logic lt, eq;
    a = longint'(x);
    b = longint'(y);
    if (s && x[w-1]) a = a - (longint'(1) << w);
    if (s && y[w-1]) b = b - (longint'(1) << w);
    lt = (a < b);
    eq = (a == b);
    case (op)
      3'd0:    return eq;
      3'd1:    return !eq;
      3'd2:    return lt;
      3'd3:    return lt || eq;
      3'd4:    return !lt && !eq;
      3'd5:    return !lt;
      default: return 1'b0;
    endcase
  endfunction

  // Operand generator biased toward equality and range extremes
  function automatic logic [15:0] pick(int w, logic [15:0] other);
    int mask;
    int r;
    mask = (1 << w) - 1;
    r = int'($urandom_range(0, 7));
    case (r)
      0:       return other;
      1:       return 16'(mask);
      2:       return 16'h0;
      3:       return 16'(1 << (w-1));
      4:       return 16'(mask >> 1);
      default: return 16'($urandom & 32'(mask));
    endcase
  endfunction

  // Single transaction through the 8/4 instance; lat = -1 on timeout
  task automatic xact8(input logic [7:0] x, input logic [7:0] y, input cmp_op_t op,
                       input logic s, output logic o, output int lat);
    @(negedge CLK);
    b8.I0 = x; b8.I1 = y; b8.OP = op; b8.SIGNED = s;
    b8.I_VALID = 1'b1; b8.O_READY = 1'b1;
    @(posedge CLK);
    lat = -1;
    o = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      b8.I_VALID = 1'b0;
      if (b8.O_VALID) begin
        lat = i;
        o = b8.O;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    #2;
    n_vec++; if (b8.O_VALID !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %b want 0", b8.O_VALID); end
    n_vec++; if (b8.O !== 1'b0) begin n_err++; $display("FAIL reset_o: got %b want 0", b8.O); end
    n_vec++; if (b16.O_VALID !== 1'b0) begin n_err++; $display("FAIL reset_ovalid16: got %b want 0", b16.O_VALID); end
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    #1;
    n_vec++; if (b8.I_READY !== 1'b1) begin n_err++; $display("FAIL reset_iready: got %b want 1", b8.I_READY); end
    // Fill the pipe with the output stalled, then reset off-edge
    @(negedge CLK);
    b8.O_READY = 1'b0; b8.I_VALID = 1'b1;
    b8.I0 = 8'h05; b8.I1 = 8'h03; b8.OP = CMP_GT; b8.SIGNED = 1'b0;
    @(negedge CLK);
    b8.I0 = 8'h01;
    @(negedge CLK);
    b8.I_VALID = 1'b0;
    n_vec++; if (b8.O_VALID !== 1'b1) begin n_err++; $display("FAIL midstream_ovalid: got %b want 1", b8.O_VALID); end
    n_vec++; if (b8.O !== 1'b1) begin n_err++; $display("FAIL midstream_o: got %b want 1", b8.O); end
    @(posedge CLK);
    #3 ASYNCRESET = 1'b1;
    #1;
    n_vec++; if (b8.O_VALID !== 1'b0) begin n_err++; $display("FAIL async_ovalid: got %b want 0", b8.O_VALID); end
    n_vec++; if (b8.O !== 1'b0) begin n_err++; $display("FAIL async_o: got %b want 0", b8.O); end
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    b8.O_READY = 1'b1;
    #1;
    n_vec++; if (b8.I_READY !== 1'b1) begin n_err++; $display("FAIL release_iready: got %b want 1", b8.I_READY); end
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      if (b8.O_VALID) seen++;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL flushed_tokens: got %0d outputs want 0", seen); end
  endtask

  task automatic test_equal();
    cmp_op_t ops [6] = '{CMP_LE, CMP_LT, CMP_EQ, CMP_NE, CMP_GT, CMP_GE};
    logic    exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic o;
    int lat;
    for (int i = 0; i < 6; i++) begin
      xact8(8'h3C, 8'h3C, ops[i], 1'b0, o, lat);
      n_vec++; if (o !== exp[i]) begin n_err++; $display("FAIL equal_op%0d: got %b want %b", ops[i], o, exp[i]); end
      n_vec++; if (lat != 2) begin n_err++; $display("FAIL equal_latency: got %0d want 2", lat); end
    end
  endtask

  task automatic test_signed();
    logic [7:0] xs  [8] = '{8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h80, 8'h3C, 8'h3C};
    logic [7:0] ys  [8] = '{8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'h7F, 8'h3C, 8'h01};
    cmp_op_t    ops [8] = '{CMP_LT, CMP_LT, CMP_GT, CMP_LT, CMP_GE, CMP_NE, 3'd6, 3'd7};
    logic       sg  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic o;
    int lat;
    for (int i = 0; i < 8; i++) begin
      xact8(xs[i], ys[i], ops[i], sg[i], o, lat);
      n_vec++;
      if (o !== exp[i] || lat != 2) begin
        n_err++;
        $display("FAIL signed_vec%0d: got O=%b lat=%0d want O=%b lat=2", i, o, lat, exp[i]);
      end
    end
  endtask

  task automatic test_carry();
    logic [7:0] xs  [4] = '{8'h10, 8'h10, 8'h0F, 8'h10};
    logic [7:0] ys  [4] = '{8'h0F, 8'h0F, 8'h10, 8'h0F};
    cmp_op_t    ops [4] = '{CMP_GT, CMP_EQ, CMP_LT, CMP_LE};
    logic       sg  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic o;
    int lat;
    for (int i = 0; i < 4; i++) begin
      xact8(xs[i], ys[i], ops[i], sg[i], o, lat);
      n_vec++;
      if (o !== exp[i] || lat != 2) begin
        n_err++;
        $display("FAIL carry_vec%0d: got O=%b lat=%0d want O=%b lat=2", i, o, lat, exp[i]);
      end
    end
  endtask

  task automatic test_latency();
    int lat;
    logic o;
    // Single-stage shape: one registered compare
    @(negedge CLK);
    b88.I0 = 8'h10; b88.I1 = 8'h0F; b88.OP = CMP_GT; b88.SIGNED = 1'b0;
    b88.I_VALID = 1'b1; b88.O_READY = 1'b1;
    @(posedge CLK);
    lat = -1; o = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      b88.I_VALID = 1'b0;
      if (b88.O_VALID) begin lat = i; o = b88.O; break; end
    end
    n_vec++; if (lat != 1 || o !== 1'b1) begin n_err++; $display("FAIL lat_stage1: got lat=%0d O=%b want lat=1 O=1", lat, o); end
    // Four-stage shape: signed min vs max
    @(negedge CLK);
    b16.I0 = 16'h8000; b16.I1 = 16'h7FFF; b16.OP = CMP_LT; b16.SIGNED = 1'b1;
    b16.I_VALID = 1'b1; b16.O_READY = 1'b1;
    @(posedge CLK);
    lat = -1; o = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      b16.I_VALID = 1'b0;
      if (b16.O_VALID) begin lat = i; o = b16.O; break; end
    end
    n_vec++; if (lat != 4 || o !== 1'b1) begin n_err++; $display("FAIL lat_stage4: got lat=%0d O=%b want lat=4 O=1", lat, o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs  [6] = '{8'h05, 8'h05, 8'hFF, 8'h20, 8'h7F, 8'h00};
    logic [7:0] ys  [6] = '{8'h03, 8'h03, 8'h01, 8'h20, 8'h80, 8'hFF};
    cmp_op_t    ops [6] = '{CMP_GT, CMP_LT, CMP_LT, CMP_GE, CMP_LT, CMP_LE};
    logic       sg  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic got [16];
    int sent, ngot, seen;
    sent = 0; ngot = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge CLK);
      b8.O_READY = !(cyc >= 3 && cyc < 6);
      b8.I_VALID = (sent < 6);
      if (sent < 6) begin
        b8.I0 = xs[sent]; b8.I1 = ys[sent]; b8.OP = ops[sent]; b8.SIGNED = sg[sent];
      end
      #1;
      if (cyc >= 3 && cyc < 6) begin
        n_vec++;
        if (b8.I_READY !== 1'b0 || b8.O_VALID !== 1'b1 || b8.O !== exp[ngot]) begin
          n_err++;
          $display("FAIL stall_cyc%0d: got I_READY=%b O_VALID=%b O=%b want 0/1/%b",
                   cyc, b8.I_READY, b8.O_VALID, b8.O, exp[ngot]);
        end
      end
      if (b8.O_VALID && b8.O_READY && ngot < 16) begin
        got[ngot] = b8.O;
        ngot++;
      end
      if (b8.I_VALID && b8.I_READY) sent++;
      if (sent == 6 && ngot >= 6) break;
    end
    @(negedge CLK);
    b8.I_VALID = 1'b0;
    b8.O_READY = 1'b1;
    n_vec++; if (ngot != 6) begin n_err++; $display("FAIL b2b_count: got %0d results want 6", ngot); end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (i >= ngot || got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL b2b_result%0d: got %b want %b", i, (i < ngot) ? got[i] : 1'bx, exp[i]);
      end
    end
    seen = 0;
    repeat (4) begin
      #1;
      if (b8.O_VALID) seen++;
      @(negedge CLK);
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL b2b_duplicate: got %0d extra results want 0", seen); end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    tok_t q16[$], q88[$], c16, c88, t;
    int acc16, acc88, got16, got88, cyc;
    acc16 = 0; acc88 = 0; got16 = 0; got88 = 0; cyc = 0;
    while ((got16 < N || got88 < N) && cyc < 60000) begin
      @(negedge CLK);
      cyc++;
      b16.O_READY = ($urandom_range(0, 3) != 0);
      b88.O_READY = ($urandom_range(0, 3) != 0);
      c16.x = pick(16, 16'h0); c16.y = pick(16, c16.x);
      c16.op = cmp_op_t'($urandom_range(0, 7)); c16.s = 1'($urandom_range(0, 1));
      c16.e = ref_cmp(16, c16.x, c16.y, c16.op, c16.s);
      c88.x = pick(8, 16'h0); c88.y = pick(8, c88.x);
      c88.op = cmp_op_t'($urandom_range(0, 7)); c88.s = 1'($urandom_range(0, 1));
      c88.e = ref_cmp(8, c88.x, c88.y, c88.op, c88.s);
      b16.I_VALID = (acc16 < N) && ($urandom_range(0, 7) != 0);
      b16.I0 = c16.x; b16.I1 = c16.y; b16.OP = c16.op; b16.SIGNED = c16.s;
      b88.I_VALID = (acc88 < N) && ($urandom_range(0, 7) != 0);
      b88.I0 = c88.x[7:0]; b88.I1 = c88.y[7:0]; b88.OP = c88.op; b88.SIGNED = c88.s;
      #1;
      if (b16.O_VALID && b16.O_READY) begin
        n_vec++;
        if (q16.size() == 0) begin
          n_err++; $display("FAIL rnd16_extra: got unexpected result %b", b16.O);
        end else begin
          t = q16.pop_front();
          got16++;
          if (b16.O !== t.e) begin
            n_err++;
            $display("FAIL rnd16: I0=%h I1=%h op=%0d s=%b got %b want %b", t.x, t.y, t.op, t.s, b16.O, t.e);
          end
        end
      end
      if (b88.O_VALID && b88.O_READY) begin
        n_vec++;
        if (q88.size() == 0) begin
          n_err++; $display("FAIL rnd88_extra: got unexpected result %b", b88.O);
        end else begin
          t = q88.pop_front();
          got88++;
          if (b88.O !== t.e) begin
            n_err++;
            $display("FAIL rnd88: I0=%h I1=%h op=%0d s=%b got %b want %b", t.x[7:0], t.y[7:0], t.op, t.s, b88.O, t.e);
          end
        end
      end
      if (b16.I_VALID && b16.I_READY) begin q16.push_back(c16); acc16++; end
      if (b88.I_VALID && b88.I_READY) begin q88.push_back(c88); acc88++; end
    end
    @(negedge CLK);
    b16.I_VALID = 1'b0;
    b88.I_VALID = 1'b0;
    n_vec++;
    if (got16 != N || got88 != N) begin
      n_err++;
      $display("FAIL rnd_timeout: got %0d/%0d results want %0d/%0d", got16, got88, N, N);
    end
  endtask

  initial begin
    b8.I_VALID = 1'b0;  b8.I0 = '0;  b8.I1 = '0;  b8.OP = CMP_EQ;  b8.SIGNED = 1'b0;  b8.O_READY = 1'b1;
    b16.I_VALID = 1'b0; b16.I0 = '0; b16.I1 = '0; b16.OP = CMP_EQ; b16.SIGNED = 1'b0; b16.O_READY = 1'b1;
    b88.I_VALID = 1'b0; b88.I0 = '0; b88.I1 = '0; b88.OP = CMP_EQ; b88.SIGNED = 1'b0; b88.O_READY = 1'b1;
    test_reset();
    test_equal();
    test_signed();
    test_carry();
    test_latency();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
